display_bcd_multiplexado: RTL and testbench
===========================================

Name: display_bcd_multiplexado

Overview:
Parametrised multi-digit driver for a time-multiplexed 7-segment display bank (common anode by default).
- Latches a packed BCD word plus per-digit decimal points into a shadow register.
- Scans the digits one at a time at a programmable refresh rate, with a one-cycle guard between digits to suppress ghosting.
- Optionally blanks leading zeros.
- Sits between the numeric datapath (counters, ALU results) and the board display pins.

Parameters:
- NUM_DIGITOS, 4: number of digits, legal range 1..8.
- DIV_REFRESCO, 50000: clock cycles each digit is driven; must be at least 2.
- ANODO_COMUN, 1: 1 = segments, dp and anodes all active-low; 0 = all active-high.
- BLANK_CEROS, 1: 1 = leading-zero blanking enabled.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  display enable
- load  in  1  latch strobe for bcd_in and dp_in
- bcd_in  in  4*NUM_DIGITOS  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 is the rightmost (least significant)
- dp_in  in  NUM_DIGITOS  decimal point request per digit
- seg  out  7  segment drive, seg[0]=a ... seg[6]=g
- dp  out  1  decimal point drive
- anodo  out  NUM_DIGITOS  digit select, one-hot-active
- digito_activo  out  max(1,clog2(NUM_DIGITOS))  index of the digit currently scanned
- fin_barrido  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst). All outputs are registered.
- Reset values:
  - seg, dp and anodo all inactive: all-ones when ANODO_COMUN=1, all-zeros when ANODO_COMUN=0.
  - digito_activo=0, fin_barrido=0.
  - Shadow register and prescaler cleared to 0; state APAGADO.
- Shadow register: on any rising edge with load=1, takes bcd_in and dp_in, regardless of state. The display only ever reads the shadow register.
- Prescaler: counts 0..DIV_REFRESCO-1 only in state MOSTRAR. tick is asserted when count = DIV_REFRESCO-1. On tick the count wraps to 0.
- State machine:
  - APAGADO: all drives inactive; prescaler=0; idx=0. Goes to GUARDA when en=1.
  - GUARDA: exactly 1 cycle; anodo inactive, seg/dp inactive. Goes to MOSTRAR.
  - MOSTRAR: the anodo bit for idx is active; seg and dp carry digit idx. On tick: go to GUARDA and advance idx (NUM_DIGITOS-1 wraps to 0).
  - From any state, en=0 forces APAGADO on the next edge.
- Digit period: DIV_REFRESCO cycles in MOSTRAR plus 1 GUARDA cycle.
- fin_barrido: pulses high for the cycle after the tick that moves idx from NUM_DIGITOS-1 to 0. With NUM_DIGITOS=1 it pulses on every tick.
- digito_activo equals the registered idx.
- Decoding:
  - Codes 0..9 map to the standard patterns; the active-low form of "0" is 1000000.
  - Codes 10..15 drive all segments inactive.
  - When ANODO_COMUN=0 the patterns are bitwise inverted.
- Leading-zero blanking (BLANK_CEROS=1): digit i>0 is blanked (seg inactive) when shadow digits i..NUM_DIGITOS-1 are all 0.
  - Digit 0 is never blanked.
  - Codes >9 count as non-zero for this test.
  - dp is unaffected by blanking.
- Latency:
  - A value loaded at edge k appears on seg from edge k+1, if the digit is in MOSTRAR.
  - Output registers lag state/idx by 0 cycles: they are computed from next-state, so anodo and seg change on the same edge as the state.
- Reset mid-scan: outputs go inactive immediately, and the scan restarts at digit 0 after rst is released and en=1.

Decomposition:
- Package display_pkg:
  - Segment constants CERO..NUEVE and APAGADO (active-low form).
  - State enum {APAGADO, GUARDA, MOSTRAR}.
  - Function computing the idx width.
- One sub-module, bcd_a_segmentos: combinational 4-bit to 7-bit decoder with a polarity parameter. Codes >9 map to APAGADO.
- Scan FSM, prescaler, shadow register and blanking logic stay in the top module.

Test Plan:
- Reset: rst pulsed asynchronously between edges -> seg=1111111, dp=1, anodo=1111 at once; digito_activo=0.
- Scan timing, N=4, DIV=4, en=1, load 0x1234 -> sequence GUARDA(anodo 1111), digit0 "4" 0011001 for 4 cycles with anodo 1110, guard, digit1 "3" with anodo 1101, and so on. fin_barrido pulses once per 20 cycles.
- Blanking: load 0x0050 -> digits 3 and 2 give seg 1111111; digit1 "5" 0010010; digit0 "0" 1000000. Load 0x0000 -> only digit0 shows "0".
- Invalid code and dp: load 0x00A7 with dp_in=0100 -> digit1 blank (not a leading zero, so digit 2 is blanked but digit... digit1 shows 1111111); digit2 blank segments with dp=0; digit0 "7" 1111000.
- en drop mid-digit-2 -> next edge APAGADO with all outputs inactive. Re-enable -> 1 guard cycle, then digit0.
- Polarity: ANODO_COMUN=0, load 0x0008 -> digit0 seg=1111111 and anodo=0001; blanked digits give seg=0000000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, scan states and helpers for the multiplexed BCD display driver.
package display_pkg;

  // Segment patterns in active-low form, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_CERO    = 7'b1000000;
  localparam logic [6:0] SEG_UNO     = 7'b1111001;
  localparam logic [6:0] SEG_DOS     = 7'b0100100;
  localparam logic [6:0] SEG_TRES    = 7'b0110000;
  localparam logic [6:0] SEG_CUATRO  = 7'b0011001;
  localparam logic [6:0] SEG_CINCO   = 7'b0010010;
  localparam logic [6:0] SEG_SEIS    = 7'b0000010;
  localparam logic [6:0] SEG_SIETE   = 7'b1111000;
  localparam logic [6:0] SEG_OCHO    = 7'b0000000;
  localparam logic [6:0] SEG_NUEVE   = 7'b0010000;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  typedef enum logic [1:0] {
    APAGADO,
    GUARDA,
    MOSTRAR
  } estado_t;

  // Digit index width; a single-digit bank still needs one bit.
  function automatic int unsigned ancho_idx(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_a_segmentos.sv
// Combinational BCD to 7-segment decoder; codes above 9 blank the digit.
module bcd_a_segmentos
  import display_pkg::*;
#(
  parameter int unsigned ANODO_COMUN = 1
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  logic [6:0] patron;

  always_comb begin
    patron = SEG_APAGADO;
    case (bcd)
      4'd0:    patron = SEG_CERO;
      4'd1:    patron = SEG_UNO;
      4'd2:    patron = SEG_DOS;
      4'd3:    patron = SEG_TRES;
      4'd4:    patron = SEG_CUATRO;
      4'd5:    patron = SEG_CINCO;
      4'd6:    patron = SEG_SEIS;
      4'd7:    patron = SEG_SIETE;
      4'd8:    patron = SEG_OCHO;
      4'd9:    patron = SEG_NUEVE;
      default: patron = SEG_APAGADO;
    endcase
    seg_c = (ANODO_COMUN != 0) ? patron : ~patron;
  end

endmodule

// File: rtl/display_bcd_multiplexado.sv
// Time-multiplexed 7-segment driver: shadow register, refresh prescaler,
// guarded digit scan and leading-zero blanking.
module display_bcd_multiplexado
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITOS  = 4,
  parameter int unsigned DIV_REFRESCO = 50000,
  parameter int unsigned ANODO_COMUN  = 1,
  parameter int unsigned BLANK_CEROS  = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    load,
  input  logic [4*NUM_DIGITOS-1:0]                bcd_in,
  input  logic [NUM_DIGITOS-1:0]                  dp_in,
  output logic [6:0]                              seg,
  output logic                                    dp,
  output logic [NUM_DIGITOS-1:0]                  anodo,
  output logic [ancho_idx(NUM_DIGITOS)-1:0]       digito_activo,
  output logic                                    fin_barrido
);

  localparam int unsigned IW = ancho_idx(NUM_DIGITOS);
  localparam int unsigned CW = $clog2(DIV_REFRESCO);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_REFRESCO - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITOS - 1);
  localparam logic INACT = (ANODO_COMUN != 0);
  localparam logic [6:0] SEG_INACT = {7{INACT}};
  localparam logic [NUM_DIGITOS-1:0] AN_INACT = {NUM_DIGITOS{INACT}};

  estado_t                  estado, estado_n;
  logic [IW-1:0]            idx_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [4*NUM_DIGITOS-1:0] bcd_sh;
  logic [NUM_DIGITOS-1:0]   dp_sh;
  logic [3:0]               digitos [NUM_DIGITOS];
  logic [NUM_DIGITOS-1:0]   blank;
  logic [NUM_DIGITOS:1]     ceros;
  logic [6:0]               seg_dec;
  logic                     tick;
  logic [6:0]               seg_n;
  logic                     dp_n;
  logic [NUM_DIGITOS-1:0]   anodo_n;
  logic                     fin_n;

  // A digit is a leading zero when it and every digit above it are zero.
  assign ceros[NUM_DIGITOS] = 1'b1;
  assign blank[0] = 1'b0;
  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_dig
    assign digitos[g] = bcd_sh[4*g +: 4];
    if (g > 0) begin : g_blank
      assign ceros[g] = ceros[g+1] & (bcd_sh[4*g +: 4] == 4'd0);
      assign blank[g] = (BLANK_CEROS != 0) & ceros[g];
    end
  end

  bcd_a_segmentos #(
    .ANODO_COMUN(ANODO_COMUN)
  ) u_dec (
    .bcd  (digitos[idx_n]),
    .seg_c(seg_dec)
  );

  assign tick = (estado == MOSTRAR) && (cnt == CNT_MAX);

  // Next state, prescaler, index and the output values they imply.
  always_comb begin
    estado_n = estado;
    idx_n    = digito_activo;
    cnt_n    = cnt;
    seg_n    = SEG_INACT;
    dp_n     = INACT;
    anodo_n  = AN_INACT;
    fin_n    = 1'b0;

    case (estado)
      APAGADO: begin
        idx_n = '0;
        cnt_n = '0;
        if (en) estado_n = GUARDA;
      end
      GUARDA: begin
        cnt_n    = '0;
        estado_n = MOSTRAR;
      end
      MOSTRAR: begin
        if (tick) begin
          cnt_n    = '0;
          estado_n = GUARDA;
          idx_n    = (digito_activo == IDX_MAX) ? '0 : digito_activo + IW'(1);
          fin_n    = en && (digito_activo == IDX_MAX);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: estado_n = APAGADO;
    endcase

    if (!en) begin
      estado_n = APAGADO;
      idx_n    = '0;
      cnt_n    = '0;
    end

    if (estado_n == MOSTRAR) begin
      anodo_n = (NUM_DIGITOS'(1) << idx_n) ^ AN_INACT;
      seg_n   = blank[idx_n] ? SEG_INACT : seg_dec;
      dp_n    = dp_sh[idx_n] ^ INACT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= APAGADO;
      cnt           <= '0;
      digito_activo <= '0;
      bcd_sh        <= '0;
      dp_sh         <= '0;
      seg           <= SEG_INACT;
      dp            <= INACT;
      anodo         <= AN_INACT;
      fin_barrido   <= 1'b0;
    end else begin
      estado        <= estado_n;
      cnt           <= cnt_n;
      digito_activo <= idx_n;
      seg           <= seg_n;
      dp            <= dp_n;
      anodo         <= anodo_n;
      fin_barrido   <= fin_n;
      if (load) begin
        bcd_sh <= bcd_in;
        dp_sh  <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_display_bcd_multiplexado.sv
// Directed bench: table of loaded words walked through two full scans, plus
// hand-written sequences for latency, enable drop, async reset and polarity.
module tb_display_bcd_multiplexado;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dpr;
    logic [27:0] segs;   // {d3,d2,d1,d0} active-low patterns
  } vec_t;

  localparam logic [6:0] B = 7'b1111111;

  logic        clk, rst;
  logic        en, load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anodo;
  logic [1:0]  digito_activo;
  logic        fin_barrido;

  logic        en2, load2;
  logic [15:0] bcd2;
  logic [3:0]  dp2;
  logic [6:0]  seg2;
  logic        dpo2;
  logic [3:0]  anodo2;
  logic [1:0]  dig2;
  logic        fin2;

  int tests;
  int failed;
  vec_t vecs [6];

  display_bcd_multiplexado #(
    .NUM_DIGITOS(4), .DIV_REFRESCO(4), .ANODO_COMUN(1), .BLANK_CEROS(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .anodo(anodo), .digito_activo(digito_activo),
    .fin_barrido(fin_barrido)
  );

  display_bcd_multiplexado #(
    .NUM_DIGITOS(4), .DIV_REFRESCO(4), .ANODO_COMUN(0), .BLANK_CEROS(1)
  ) dut_ac (
    .clk(clk), .rst(rst), .en(en2), .load(load2), .bcd_in(bcd2), .dp_in(dp2),
    .seg(seg2), .dp(dpo2), .anodo(anodo2), .digito_activo(dig2),
    .fin_barrido(fin2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] pack1();
    return {fin_barrido, digito_activo, dp, anodo, seg};
  endfunction

  function automatic logic [14:0] pack2();
    return {fin2, dig2, dpo2, anodo2, seg2};
  endfunction

  // Expected {fin,idx,dp,anodo,seg} at cycle c (c=1 is the first guard) with DIV=4.
  function automatic logic [14:0] esperado(input vec_t v, input int c);
    int ph;
    int d;
    logic [1:0] di;
    logic [3:0] an;
    logic [3:0] uno;
    ph  = (c - 1) % 5;
    d   = ((c - 1) / 5) % 4;
    di  = 2'(d);
    uno = 4'b0001;
    if (ph == 0) return {(c > 1) && (d == 0), di, 1'b1, 4'hF, B};
    an = ~(uno << d);
    return {1'b0, di, ~v.dpr[d], an, v.segs[7*d +: 7]};
  endfunction

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
    en2 = 1'b0; load2 = 1'b0; bcd2 = '0; dp2 = '0;

    vecs[0] = '{16'h1234, 4'b0000, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{16'h0050, 4'b0000, {B, B, 7'b0010010, 7'b1000000}};
    vecs[2] = '{16'h0000, 4'b0000, {B, B, B, 7'b1000000}};
    vecs[3] = '{16'h00A7, 4'b0100, {B, B, B, 7'b1111000}};
    vecs[4] = '{16'h9806, 4'b1001, {7'b0010000, 7'b0000000, 7'b1000000, 7'b0000010}};
    vecs[5] = '{16'h0F00, 4'b1000, {B, B, 7'b1000000, 7'b1000000}};

    #3;
    chk("reset_ac1", pack1(), {1'b0, 2'd0, 1'b1, 4'hF, B});
    chk("reset_ac0", pack2(), {1'b0, 2'd0, 1'b0, 4'h0, 7'h00});
    step();
    rst = 1'b0;

    // Table: load with display off, enable, walk two full scans.
    for (int i = 0; i < 6; i++) begin
      en = 1'b0; load = 1'b1; bcd_in = vecs[i].bcd; dp_in = vecs[i].dpr;
      step();
      load = 1'b0; en = 1'b1;
      for (int c = 1; c <= 41; c++) begin
        step();
        chk($sformatf("vec%0d_c%0d", i, c), pack1(), esperado(vecs[i], c));
      end
    end

    // Load latency: new value shows one edge after the load edge.
    en = 1'b0; load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000;
    step();
    load = 1'b0; en = 1'b1;
    step();
    step();
    chk("lat_before", pack1(), {1'b0, 2'd0, 1'b1, 4'b1110, 7'b0011001});
    load = 1'b1; bcd_in = 16'h1231;
    step();
    load = 1'b0;
    chk("lat_load_edge", pack1(), {1'b0, 2'd0, 1'b1, 4'b1110, 7'b0011001});
    step();
    chk("lat_after", pack1(), {1'b0, 2'd0, 1'b1, 4'b1110, 7'b1111001});

    // Enable drop in the middle of digit 2, then re-enable.
    en = 1'b0; load = 1'b1; bcd_in = 16'h1234;
    step();
    load = 1'b0; en = 1'b1;
    for (int c = 1; c <= 13; c++) step();
    chk("en_mid_d2", pack1(), {1'b0, 2'd2, 1'b1, 4'b1011, 7'b0100100});
    en = 1'b0;
    step();
    chk("en_drop", pack1(), {1'b0, 2'd0, 1'b1, 4'hF, B});
    en = 1'b1;
    step();
    chk("en_guard", pack1(), {1'b0, 2'd0, 1'b1, 4'hF, B});
    step();
    chk("en_digit0", pack1(), {1'b0, 2'd0, 1'b1, 4'b1110, 7'b0011001});

    // Asynchronous reset between edges, then scan restarts from cleared shadow.
    for (int c = 0; c < 6; c++) step();
    chk("pre_rst_d1", pack1(), {1'b0, 2'd1, 1'b1, 4'b1101, 7'b0110000});
    #2 rst = 1'b1;
    #1;
    chk("rst_async", pack1(), {1'b0, 2'd0, 1'b1, 4'hF, B});
    step();
    rst = 1'b0;
    step();
    chk("rst_guard", pack1(), {1'b0, 2'd0, 1'b1, 4'hF, B});
    step();
    chk("rst_digit0", pack1(), {1'b0, 2'd0, 1'b1, 4'b1110, 7'b1000000});

    // Active-high polarity instance.
    load2 = 1'b1; bcd2 = 16'h0008; dp2 = 4'b0000;
    step();
    load2 = 1'b0; en2 = 1'b1;
    step();
    chk("ac0_guard", pack2(), {1'b0, 2'd0, 1'b0, 4'h0, 7'h00});
    step();
    chk("ac0_digit0", pack2(), {1'b0, 2'd0, 1'b0, 4'b0001, 7'b1111111});
    for (int c = 0; c < 3; c++) step();
    step();
    chk("ac0_guard1", pack2(), {1'b0, 2'd1, 1'b0, 4'h0, 7'h00});
    step();
    chk("ac0_digit1", pack2(), {1'b0, 2'd1, 1'b0, 4'b0010, 7'b0000000});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
